// File: rtl/data.sv
// Shared definitions for the camera capture path: nominal sensor geometry and
// the capture FSM state encoding.
package data;
   localparam int CAMERA_WIDTH  = 320;
   localparam int CAMERA_HEIGHT = 240;

   // BYTE_HI / BYTE_LO name the next byte expected within a row.
   typedef enum logic [2:0] {
      SYNC_WAIT,
      VBLANK,
      HBLANK,
      BYTE_HI,
      BYTE_LO
   } capture_state_t;
endpackage

// File: rtl/camera_capture_byte_pair_assembler.sv
// Pairs consecutive row bytes into one 16-bit word. The phase restarts whenever
// the byte stream pauses, so every row begins on a high byte.
module byte_pair_assembler (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        take,
   input  logic [7:0]  byte_in,
   output logic [15:0] word,
   output logic        pair
);
   logic [7:0] hi_q;
   logic       phase_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hi_q    <= '0;
         phase_q <= 1'b0;
      end else begin
         if (take && !phase_q) hi_q <= byte_in;
         phase_q <= take ? ~phase_q : 1'b0;
      end
   end

   assign word = {hi_q, byte_in};
   assign pair = take & phase_q;
endmodule

// File: rtl/camera_capture.sv
// OV7670 byte stream to RGB565 pixels with frame coordinates, plus per-frame
// completion and integrity status.
module camera_capture
   import data::*;
#(
   parameter int FRAME_WIDTH  = CAMERA_WIDTH,
   parameter int FRAME_HEIGHT = CAMERA_HEIGHT
) (
   input  logic        pixel_clock_in,
   input  logic        rst_n_in,
   input  logic        cam_vsync_in,
   input  logic        cam_href_in,
   input  logic [7:0]  cam_data_in,
   output logic [9:0]  frame_x_count,
   output logic [8:0]  frame_y_count,
   output logic [15:0] pixel_data,
   output logic        pixel_valid,
   output logic        frame_done,
   output logic        frame_error
);
   localparam logic [10:0] WIDTH_L  = 11'(FRAME_WIDTH);
   localparam logic [9:0]  HEIGHT_L = 10'(FRAME_HEIGHT);
   localparam logic [9:0]  X_MAX    = 10'h3FF;
   localparam logic [8:0]  Y_MAX    = 9'h1FF;

   capture_state_t state;
   logic        vsync_q, href_q;
   logic [7:0]  data_q;
   logic        inc_pend, err_acc;
   logic        take, pair, in_row, row_bad;
   logic [15:0] word;
   logic [10:0] row_px;
   logic [9:0]  rows;

   // x advances one cycle after the strobe so the strobe carries its own x.
   assign in_row  = (state == BYTE_HI) || (state == BYTE_LO);
   assign take    = (in_row || state == HBLANK) && href_q && !vsync_q;
   assign row_px  = {1'b0, frame_x_count} + {10'd0, inc_pend};
   assign row_bad = (row_px != WIDTH_L) || (state == BYTE_LO);
   assign rows    = {1'b0, frame_y_count} + {9'd0, in_row};

   byte_pair_assembler u_pair (
      .clk     (pixel_clock_in),
      .rst_n   (rst_n_in),
      .take    (take),
      .byte_in (data_q),
      .word    (word),
      .pair    (pair)
   );

   always_ff @(posedge pixel_clock_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         vsync_q       <= 1'b0;
         href_q        <= 1'b0;
         data_q        <= '0;
         state         <= SYNC_WAIT;
         frame_x_count <= '0;
         frame_y_count <= '0;
         pixel_data    <= '0;
         pixel_valid   <= 1'b0;
         frame_done    <= 1'b0;
         frame_error   <= 1'b0;
         inc_pend      <= 1'b0;
         err_acc       <= 1'b0;
      end else begin
         vsync_q     <= cam_vsync_in;
         href_q      <= cam_href_in;
         data_q      <= cam_data_in;
         pixel_valid <= 1'b0;
         frame_done  <= 1'b0;
         inc_pend    <= 1'b0;
         if (inc_pend && frame_x_count != X_MAX) frame_x_count <= frame_x_count + 10'd1;
         case (state)
            SYNC_WAIT: if (vsync_q) state <= VBLANK;
            VBLANK: begin
               frame_x_count <= '0;
               frame_y_count <= '0;
               if (!vsync_q) state <= HBLANK;
            end
            default: begin
               if (vsync_q) begin
                  state         <= VBLANK;
                  frame_x_count <= '0;
                  frame_y_count <= '0;
                  err_acc       <= 1'b0;
                  if (frame_y_count != '0 || in_row) begin
                     frame_done  <= 1'b1;
                     frame_error <= err_acc || (in_row && row_bad) || (rows != HEIGHT_L);
                  end
               end else if (pair) begin
                  pixel_data  <= word;
                  pixel_valid <= ({1'b0, frame_x_count} < WIDTH_L) &&
                                 ({1'b0, frame_y_count} < HEIGHT_L);
                  inc_pend    <= 1'b1;
                  state       <= BYTE_HI;
               end else if (href_q) begin
                  state <= BYTE_LO;
               end else if (in_row) begin
                  // End of row; an odd byte count lands here from BYTE_LO.
                  frame_x_count <= '0;
                  if (frame_y_count != Y_MAX) frame_y_count <= frame_y_count + 9'd1;
                  err_acc <= err_acc || row_bad;
                  state   <= HBLANK;
               end
            end
         endcase
      end
   end
endmodule

// File: tb/tb_camera_capture.sv
// Scoreboard bench for camera_capture on a reduced 16x8 frame geometry.
module tb_camera_capture;
   localparam int W = 16;
   localparam int H = 8;

   logic        pixel_clock_in = 1'b0;
   logic        rst_n_in = 1'b1;
   logic        cam_vsync_in = 1'b0;
   logic        cam_href_in = 1'b0;
   logic [7:0]  cam_data_in = 8'h00;
   logic [9:0]  frame_x_count;
   logic [8:0]  frame_y_count;
   logic [15:0] pixel_data;
   logic        pixel_valid, frame_done, frame_error;

   camera_capture #(.FRAME_WIDTH(W), .FRAME_HEIGHT(H)) dut (
      .pixel_clock_in (pixel_clock_in),
      .rst_n_in       (rst_n_in),
      .cam_vsync_in   (cam_vsync_in),
      .cam_href_in    (cam_href_in),
      .cam_data_in    (cam_data_in),
      .frame_x_count  (frame_x_count),
      .frame_y_count  (frame_y_count),
      .pixel_data     (pixel_data),
      .pixel_valid    (pixel_valid),
      .frame_done     (frame_done),
      .frame_error    (frame_error)
   );

   always #5 pixel_clock_in = ~pixel_clock_in;

   typedef struct packed {
      logic [9:0]  x;
      logic [8:0]  y;
      logic [15:0] d;
   } pix_t;

   pix_t pq[$];
   bit   eq[$];
   int   checks = 0, failures = 0, strobes = 0;
   logic [9:0] last_x = '0;
   logic [8:0] last_y = '0;
   bit   prev_valid = 1'b0;
   bit   pattern = 1'b0;
   bit   expect_on = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   // Monitor: every strobe / frame_done pops the next expectation.
   always @(negedge pixel_clock_in) begin
      if (pixel_valid) begin
         pix_t e;
         strobes++;
         check("strobe_spacing", {31'd0, prev_valid}, 32'd0);
         checks++;
         if (pq.size() == 0) begin
            failures++;
            $display("FAIL unexpected_strobe actual x=%0d y=%0d d=%0h required none",
                     frame_x_count, frame_y_count, pixel_data);
         end else begin
            e = pq.pop_front();
            check("pixel_x", {22'd0, frame_x_count}, {22'd0, e.x});
            check("pixel_y", {23'd0, frame_y_count}, {23'd0, e.y});
            check("pixel_data", {16'd0, pixel_data}, {16'd0, e.d});
            last_x = frame_x_count;
            last_y = frame_y_count;
         end
      end
      prev_valid = pixel_valid;
      if (frame_done) begin
         checks++;
         if (eq.size() == 0) begin
            failures++;
            $display("FAIL unexpected_frame_done actual=1 required=0");
         end else begin
            check("frame_error", {31'd0, frame_error}, {31'd0, eq.pop_front()});
         end
      end
   end

   task automatic cyc(input logic v, input logic h, input logic [7:0] d);
      @(posedge pixel_clock_in);
      #1;
      cam_vsync_in = v;
      cam_href_in  = h;
      cam_data_in  = d;
   endtask

   function automatic logic [15:0] pix_val(input int x, input int y);
      logic [7:0] xb, yb;
      xb = 8'(x);
      yb = 8'(y);
      return pattern ? {yb, xb} : 16'hF81F;
   endfunction

   task automatic send_pix(input int x, input int y);
      logic [15:0] v;
      v = pix_val(x, y);
      if (expect_on && x < W && y < H) pq.push_back({10'(x), 9'(y), v});
      cyc(1'b0, 1'b1, v[15:8]);
      cyc(1'b0, 1'b1, v[7:0]);
   endtask

   task automatic send_row(input int y, input int npix, input bit extra);
      for (int i = 0; i < npix; i++) send_pix(i, y);
      if (extra) cyc(1'b0, 1'b1, 8'hAA);
      repeat (4) cyc(1'b0, 1'b0, 8'h00);
   endtask

   task automatic vsync_pulse(input bit exp_done, input bit exp_err);
      if (exp_done) eq.push_back(exp_err);
      cyc(1'b1, cam_href_in, cam_data_in);
      repeat (3) cyc(1'b1, 1'b0, 8'h00);
      check("vblank_x", {22'd0, frame_x_count}, 32'd0);
      check("vblank_y", {23'd0, frame_y_count}, 32'd0);
      repeat (4) cyc(1'b0, 1'b0, 8'h00);
   endtask

   initial begin
      int s0;
      logic [15:0] v3;
      #2 rst_n_in = 1'b0;
      #1;
      check("rst_x", {22'd0, frame_x_count}, 32'd0);
      check("rst_y", {23'd0, frame_y_count}, 32'd0);
      check("rst_data", {16'd0, pixel_data}, 32'd0);
      check("rst_valid", {31'd0, pixel_valid}, 32'd0);
      check("rst_done", {31'd0, frame_done}, 32'd0);
      check("rst_error", {31'd0, frame_error}, 32'd0);

      // Release reset mid-row; nothing may come out before a VSYNC.
      for (int i = 0; i < 10; i++) begin
         cyc(1'b0, 1'b1, 8'(i));
         if (i == 4) rst_n_in = 1'b1;
      end
      send_row(0, 12, 1'b0);
      send_row(1, W, 1'b0);
      check("no_strobe_before_vsync", strobes, 32'd0);

      expect_on = 1'b1;
      vsync_pulse(1'b0, 1'b0);
      pattern = 1'b0;
      for (int y = 0; y < H; y++) send_row(y, W, 1'b0);
      check("clean_last_x", {22'd0, last_x}, W - 1);
      check("clean_last_y", {23'd0, last_y}, H - 1);
      check("clean_strobes", strobes, W * H);

      vsync_pulse(1'b1, 1'b0);
      pattern = 1'b1;
      for (int y = 0; y < H; y++) send_row(y, W, 1'b0);

      // Odd byte count on row 5.
      vsync_pulse(1'b1, 1'b0);
      for (int y = 0; y < H; y++) send_row(y, W, y == 5);

      // Oversize frame.
      vsync_pulse(1'b1, 1'b1);
      s0 = strobes;
      for (int y = 0; y < H + 10; y++) send_row(y, W + 10, 1'b0);
      check("oversize_strobes", strobes - s0, W * H);

      // VSYNC mid-row with href still high.
      vsync_pulse(1'b1, 1'b1);
      for (int y = 0; y < 5; y++) send_row(y, W, 1'b0);
      for (int i = 0; i < 10; i++) send_pix(i, 5);
      vsync_pulse(1'b1, 1'b1);
      for (int y = 0; y < H; y++) send_row(y, W, 1'b0);
      vsync_pulse(1'b1, 1'b0);

      // Asynchronous reset during a strobe.
      for (int i = 0; i < 3; i++) send_pix(i, 0);
      v3 = pix_val(3, 0);
      cyc(1'b0, 1'b1, v3[15:8]);
      cyc(1'b0, 1'b1, v3[7:0]);
      @(posedge pixel_clock_in);
      @(posedge pixel_clock_in);
      #2;
      check("strobe_before_reset", {31'd0, pixel_valid}, 32'd1);
      check("strobe_before_reset_x", {22'd0, frame_x_count}, 32'd3);
      check("strobe_before_reset_data", {16'd0, pixel_data}, {16'd0, v3});
      rst_n_in = 1'b0;
      #1;
      check("async_rst_valid", {31'd0, pixel_valid}, 32'd0);
      check("async_rst_data", {16'd0, pixel_data}, 32'd0);
      check("async_rst_x", {22'd0, frame_x_count}, 32'd0);
      expect_on = 1'b0;
      s0 = strobes;
      for (int i = 3; i < 6; i++) send_pix(i, 0);
      rst_n_in = 1'b1;
      for (int i = 6; i < W; i++) send_pix(i, 0);
      repeat (4) cyc(1'b0, 1'b0, 8'h00);
      for (int y = 1; y < H; y++) send_row(y, W, 1'b0);
      check("no_strobe_after_reset", strobes - s0, 32'd0);

      expect_on = 1'b1;
      vsync_pulse(1'b0, 1'b0);
      for (int y = 0; y < H; y++) send_row(y, W, 1'b0);
      check("resume_strobes", strobes - s0, W * H);
      vsync_pulse(1'b1, 1'b0);

      for (int i = 0; i < 50 && (pq.size() != 0 || eq.size() != 0); i++)
         @(posedge pixel_clock_in);
      check("pixels_outstanding", pq.size(), 32'd0);
      check("frames_outstanding", eq.size(), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
